// File: rtl/interval_timer.sv
// Countdown interval timer for the traffic-light FSM: loads a selected interval on Start_Timer
// and pulses Expired after that many one-second ticks. Optional macro INTERVAL_PROG_EN makes the intervals writable.
module interval_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 4,
    parameter int BASE_SEC = 6,
    parameter int EXT_SEC  = 3,
    parameter int YEL_SEC  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start_Timer,
    input  logic [1:0]       Interval_Select,
    input  logic             Prog_Sync,
    input  logic [1:0]       Prog_Select,
    input  logic [CNT_W-1:0] Prog_Value,
    output logic             Expired,
    output logic             Busy,
    output logic [CNT_W-1:0] Seconds_Left
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE_SEC   = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic [CNT_W-1:0] base_iv, ext_iv, yel_iv;
    logic [CNT_W-1:0] load_raw, load_val;
    logic             tick;

    function automatic logic [CNT_W-1:0] pick_interval(
        input logic [1:0]       sel,
        input logic [CNT_W-1:0] base_v,
        input logic [CNT_W-1:0] ext_v,
        input logic [CNT_W-1:0] yel_v
    );
        case (sel)
            2'b01:   return ext_v;
            2'b10:   return yel_v;
            default: return base_v;
        endcase
    endfunction

`ifdef INTERVAL_PROG_EN
    logic [CNT_W-1:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;

    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (Prog_Sync) begin
            case (Prog_Select)
                2'b01:   ext_d  = Prog_Value;
                2'b10:   yel_d  = Prog_Value;
                default: base_d = Prog_Value;
            endcase
        end
    end

    // Registers update at the edge, so a same-cycle Start_Timer still loads the old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q <= CNT_W'(BASE_SEC);
            ext_q  <= CNT_W'(EXT_SEC);
            yel_q  <= CNT_W'(YEL_SEC);
        end else begin
            base_q <= base_d;
            ext_q  <= ext_d;
            yel_q  <= yel_d;
        end
    end

    assign base_iv = base_q;
    assign ext_iv  = ext_q;
    assign yel_iv  = yel_q;
`else
    logic unused_prog;
    assign unused_prog = ^{Prog_Sync, Prog_Select, Prog_Value};

    assign base_iv = CNT_W'(BASE_SEC);
    assign ext_iv  = CNT_W'(EXT_SEC);
    assign yel_iv  = CNT_W'(YEL_SEC);
`endif

    assign load_raw = pick_interval(Interval_Select, base_iv, ext_iv, yel_iv);
    assign load_val = (load_raw == '0) ? ONE_SEC : load_raw;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            secs_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
        end
    end

    // A restart always beats the terminal tick of a running count.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        secs_d  = secs_q;
        if (Start_Timer) begin
            state_d = RUN;
            presc_d = '0;
            secs_d  = load_val;
        end else if (state_q == RUN) begin
            if (tick) begin
                presc_d = '0;
                if (secs_q <= ONE_SEC) begin
                    secs_d  = '0;
                    state_d = IDLE;
                end else begin
                    secs_d = secs_q - ONE_SEC;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            presc_d = '0;
            secs_d  = '0;
        end
    end

    always_comb begin
        Busy         = (state_q == RUN);
        Seconds_Left = secs_q;
        Expired      = tick && (secs_q == ONE_SEC) && !Start_Timer;
    end

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer with TICK_DIV=4 and default intervals.
module tb_interval_timer;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       Start_Timer = 1'b0;
    logic [1:0] Interval_Select = 2'b00;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Prog_Select = 2'b00;
    logic [3:0] Prog_Value = 4'd0;
    logic       Expired;
    logic       Busy;
    logic [3:0] Seconds_Left;

    int checks = 0;
    int failures = 0;

    interval_timer #(.TICK_DIV(TD), .CNT_W(4), .BASE_SEC(6), .EXT_SEC(3), .YEL_SEC(2)) dut (
        .clock(clock), .reset(reset), .Start_Timer(Start_Timer), .Interval_Select(Interval_Select),
        .Prog_Sync(Prog_Sync), .Prog_Select(Prog_Select), .Prog_Value(Prog_Value),
        .Expired(Expired), .Busy(Busy), .Seconds_Left(Seconds_Left)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start pulse in the current cycle; returns in cycle +1 with inputs idle.
    task automatic pulse_start(input logic [1:0] sel);
        Start_Timer = 1'b1;
        Interval_Select = sel;
        step();
        Start_Timer = 1'b0;
        Prog_Sync = 1'b0;
        Interval_Select = ~sel;
        #1;
    endtask

    // Cycle k after the start: secs = n - (k-1)/TD, Expired only at k = n*TD, idle afterwards.
    task automatic run_check(input string name, input int n, input int k0, input int kmax);
        for (int k = k0; k <= kmax; k++) begin
            int es, eb, ee;
            es = (k <= n * TD) ? n - (k - 1) / TD : 0;
            eb = (k <= n * TD) ? 1 : 0;
            ee = (k == n * TD) ? 1 : 0;
            check($sformatf("%s_secs_k%0d", name, k), int'(Seconds_Left), es);
            check($sformatf("%s_busy_k%0d", name, k), int'(Busy), eb);
            check($sformatf("%s_exp_k%0d", name, k), int'(Expired), ee);
            if (k < kmax) step();
        end
    endtask

    initial begin
        int seen;
        #2;
        check("rst_exp", int'(Expired), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_secs", int'(Seconds_Left), 0);
        #10 reset = 1'b1;
        step();

        // 1-2: every select, including 11 falling back to base
        pulse_start(2'b00); run_check("base", 6, 1, 28);
        pulse_start(2'b01); run_check("ext", 3, 1, 16);
        pulse_start(2'b10); run_check("yel", 2, 1, 12);
        pulse_start(2'b11); run_check("sel11", 6, 1, 28);

        // 3: restart at +10 with yellow -> expires at +18, nothing at +24
        pulse_start(2'b00);
        for (int k = 1; k < 10; k++) begin
            check($sformatf("restart_pre_k%0d", k), int'(Expired), 0);
            step();
        end
        pulse_start(2'b10);
        run_check("restart", 2, 1, 16);

        // 4: restart coincident with the terminal tick of a yellow count
        pulse_start(2'b10);
        for (int k = 1; k < 8; k++) step();
        Start_Timer = 1'b1;
        Interval_Select = 2'b01;
        #1;
        check("coinc_exp", int'(Expired), 0);
        check("coinc_secs", int'(Seconds_Left), 1);
        pulse_start(2'b01);
        run_check("coinc_new", 3, 1, 16);

        // 5: reset mid-count
        pulse_start(2'b00);
        for (int k = 1; k < 9; k++) step();
        reset = 1'b0;
        #1;
        check("midrst_busy", int'(Busy), 0);
        check("midrst_secs", int'(Seconds_Left), 0);
        check("midrst_exp", int'(Expired), 0);
        step();
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (Expired || Busy) seen++;
            step();
        end
        check("midrst_quiet", seen, 0);

`ifdef INTERVAL_PROG_EN
        // 6: writes during a run apply only to the next start
        pulse_start(2'b01);
        Prog_Sync = 1'b1; Prog_Select = 2'b01; Prog_Value = 4'd5;
        step();
        Prog_Sync = 1'b0;
        #1;
        run_check("prog_run", 3, 2, 16);
        pulse_start(2'b01); run_check("prog_ext5", 5, 1, 24);
        Prog_Sync = 1'b1; Prog_Select = 2'b01; Prog_Value = 4'd0;
        step();
        Prog_Sync = 1'b0;
        #1;
        pulse_start(2'b01); run_check("prog_ext0", 1, 1, 8);
        Prog_Sync = 1'b1; Prog_Select = 2'b10; Prog_Value = 4'd4;
        pulse_start(2'b10); run_check("prog_same_old", 2, 1, 12);
        pulse_start(2'b10); run_check("prog_same_new", 4, 1, 20);
`else
        // Writes are ignored without the programming feature
        Prog_Sync = 1'b1; Prog_Select = 2'b01; Prog_Value = 4'd5;
        step();
        Prog_Sync = 1'b0;
        #1;
        pulse_start(2'b01); run_check("noprog_ext", 3, 1, 16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
